wavegen_ctrl: RTL and testbench
===============================

// Module: wavegen_ctrl
// PURPOSE
//   Playback sequencer for the waveform generator. Takes 8-bit command bytes from the SPI client.
//   Decodes wave select, run/stop and rate, and drives the wave memory with a one-cycle sample-enable tick.
//   Also drives the wave memory address and a flush (memory reset) pulse, replacing the derived output clock.
//   Sits between spi_client and the wave memory; everything runs on the single system clock.
// PARAMETERS
//   NUM_WAVES     4    number of stored waveforms; legal selector range 0..NUM_WAVES-1 (max 16)
//   DEPTH         256  samples per waveform (power of two, >=2); IDX_W = $clog2(DEPTH)
//   BASE_DIV      100  clk cycles per sample at rate code 0 (>=1)
//   FLUSH_CYCLES  2    length of mem_rst pulse after each accepted command (>=1)
// PORTS
//   clk          in   1        system clock
//   rst          in   1        asynchronous, active-high reset
//   cmd          in   8        command byte: [7:4] wave select, [3] run(1)/stop(0), [2:0] rate code
//   cmd_valid    in   1        command strobe, clk-synchronous; accepted on its rising edge only
//   wave_sel     out  4        currently selected waveform
//   sample_addr  out  4+IDX_W  {wave_sel, sample index} to wave memory
//   sample_tick  out  1        one-cycle enable: memory registers sample at sample_addr
//   mem_rst      out  1        flush pulse to memory/output stage
//   running      out  1        high while in RUN
//   cmd_err      out  1        sticky: an illegal selector was received
// BEHAVIOUR
//   Reset values
//   - All outputs 0; FSM = IDLE; divider, index, rate and edge-detect register cleared.
//   Command accept
//   - Occurs in a cycle where cmd_valid=1 and cmd_valid was 0 in the previous cycle.
//   - A level held high for N cycles counts once.
//   - If cmd[7:4] >= NUM_WAVES: command dropped, cmd_err <= 1, state/outputs unchanged.
//   - cmd_err clears only on rst.
//   - If legal: on the accept edge, wave_sel <= cmd[7:4]; rate and run bit are latched.
//   - Also on that edge: index <= 0, divider <= 0, FSM -> FLUSH.
//   - Accept is legal in any state. A new command during FLUSH restarts the full FLUSH count (last wins).
//   FSM states
//   - IDLE: mem_rst=0, sample_tick=0, running=0; index holds.
//   - FLUSH: mem_rst=1 for exactly FLUSH_CYCLES cycles; sample_tick=0; running=0.
//     At the end: -> RUN if the latched run bit is 1, else -> IDLE.
//   - RUN: running=1.
//     - Divider counts 0..P-1, with P = BASE_DIV << rate (rate 0..7, divider width sized for BASE_DIV<<7).
//     - sample_tick=1 in the cycle the divider equals P-1; the divider then wraps to 0.
//     - The index increments in the same edge as the tick and wraps DEPTH-1 -> 0 with no gap.
//     - First tick occurs P cycles after entering RUN; sample_addr index 0 is presented during that period.
//   Simultaneous events
//   - Legal accept in the same cycle as a would-be tick: accept wins.
//   - In that case the tick is suppressed (sample_tick=0) and the index resets rather than increments.
//   Stop command
//   - A legal command with bit3=0 still flushes, then idles with index 0 and the new wave_sel.
//   Reset mid-operation
//   - Asynchronous rst forces reset values immediately, with no pending command retained.
//   Latency
//   - cmd_valid rise -> mem_rst high: next clk edge.
//   - -> running high: FLUSH_CYCLES+1 edges.
//   - -> first sample_tick: FLUSH_CYCLES+P edges after the accept.
// TESTING
//   - Reset: rst pulse mid-cycle -> all outputs 0 asynchronously; no tick for 5000 cycles.
//   - cmd=0x19 (wave 1, run, rate 1):
//     - mem_rst high exactly 2 cycles; then running=1.
//     - sample_tick every 200 cycles; sample_addr 0x100,0x101,...
//   - DEPTH=8, BASE_DIV=1, cmd=0x08: addr 0x00..0x07 then 0x00, a tick every cycle, no gap at wrap.
//   - cmd=0x58 with NUM_WAVES=4 -> cmd_err=1, wave_sel/running/sample_addr unchanged, no mem_rst.
//   - Command in the cycle of a tick:
//     - BASE_DIV=4, running wave 0, then cmd=0x28 arriving on the tick cycle.
//     - Expect no tick that cycle, flush, then index restarts at 0x200.
//   - Holding cmd_valid=1 for 50 cycles: single flush; cmd=0x30 while running -> flush then IDLE, no ticks, wave_sel=3.

Source files
------------

// File: rtl/wavegen_ctrl.sv
// wavegen_ctrl: playback sequencer for the waveform generator.
// Decodes command bytes from the SPI client into wave select, run/stop and rate,
// then steps a sample index through the selected waveform with a one-cycle tick.
module wavegen_ctrl #(
   parameter int unsigned NUM_WAVES    = 4,
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned BASE_DIV     = 100,
   parameter int unsigned FLUSH_CYCLES = 2,
   localparam int unsigned IDX_W       = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           cmd,
   input  logic                 cmd_valid,
   output logic [3:0]           wave_sel,
   output logic [4+IDX_W-1:0]   sample_addr,
   output logic                 sample_tick,
   output logic                 mem_rst,
   output logic                 running,
   output logic                 cmd_err
);

   // Divider must hold the longest period, BASE_DIV << 7.
   localparam int unsigned DIV_W = $clog2((BASE_DIV << 7) + 1);
   localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StFlush, StRun} state_e;

   state_e             state_q, state_d;
   logic               cmd_valid_q;
   logic [3:0]         wave_sel_q, wave_sel_d;
   logic [2:0]         rate_q, rate_d;
   logic               run_q, run_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
   logic               cmd_err_q, cmd_err_d;

   logic               accept;
   logic               sel_legal;
   logic               legal_accept;
   logic [DIV_W-1:0]   period;
   logic               div_last;
   logic               flush_done;
   logic               tick_due;

   // Rising-edge detect on the command strobe and selector range check.
   always_comb begin
      accept       = cmd_valid & ~cmd_valid_q;
      sel_legal    = ({28'd0, cmd[7:4]} < NUM_WAVES);
      legal_accept = accept & sel_legal;
      period       = DIV_W'(BASE_DIV) << rate_q;
      div_last     = (div_q == period - DIV_W'(1));
      flush_done   = (flush_cnt_q == FL_W'(FLUSH_CYCLES - 1));
      tick_due     = (state_q == StRun) && div_last;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a legal accept restarts the flush from any state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StIdle;
         StFlush: begin
            if (flush_done) begin
               state_d = run_q ? StRun : StIdle;
            end
         end
         StRun:   state_d = StRun;
         default: state_d = StIdle;
      endcase
      if (legal_accept) begin
         state_d = StFlush;
      end
   end

   // FSM outputs; an accepting edge suppresses a coincident tick.
   always_comb begin
      mem_rst     = 1'b0;
      running     = 1'b0;
      sample_tick = 1'b0;
      unique case (state_q)
         StIdle:  ;
         StFlush: mem_rst = 1'b1;
         StRun: begin
            running     = 1'b1;
            sample_tick = tick_due & ~legal_accept;
         end
         default: ;
      endcase
   end

   // Datapath registers: command latch, divider, index, flush counter, error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_valid_q <= 1'b0;
         wave_sel_q  <= '0;
         rate_q      <= '0;
         run_q       <= 1'b0;
         idx_q       <= '0;
         div_q       <= '0;
         flush_cnt_q <= '0;
         cmd_err_q   <= 1'b0;
      end else begin
         cmd_valid_q <= cmd_valid;
         wave_sel_q  <= wave_sel_d;
         rate_q      <= rate_d;
         run_q       <= run_d;
         idx_q       <= idx_d;
         div_q       <= div_d;
         flush_cnt_q <= flush_cnt_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   // Datapath next state.
   always_comb begin
      wave_sel_d  = wave_sel_q;
      rate_d      = rate_q;
      run_d       = run_q;
      idx_d       = idx_q;
      div_d       = div_q;
      flush_cnt_d = flush_cnt_q;
      cmd_err_d   = cmd_err_q;

      if (accept && !sel_legal) begin
         cmd_err_d = 1'b1;
      end

      if (legal_accept) begin
         wave_sel_d  = cmd[7:4];
         run_d       = cmd[3];
         rate_d      = cmd[2:0];
         idx_d       = '0;
         div_d       = '0;
         flush_cnt_d = '0;
      end else begin
         unique case (state_q)
            StFlush: begin
               flush_cnt_d = flush_done ? '0 : flush_cnt_q + FL_W'(1);
               div_d       = '0;
            end
            StRun: begin
               if (div_last) begin
                  div_d = '0;
                  // Power-of-two depth: natural overflow gives the wrap.
                  idx_d = idx_q + IDX_W'(1);
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign wave_sel    = wave_sel_q;
   assign sample_addr = {wave_sel_q, idx_q};
   assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_wavegen_ctrl.sv
// Bench for wavegen_ctrl: directed scenarios plus random command traffic, all outputs
// compared every cycle against a cycle-count model of the playback behaviour.
module tb_wavegen_ctrl;

   localparam int unsigned NW    = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned BDIV  = 4;
   localparam int unsigned FC    = 2;
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic               clk = 1'b0;
   logic               rst;
   logic [7:0]         cmd;
   logic               cmd_valid;
   logic [3:0]         wave_sel;
   logic [4+IDX_W-1:0] sample_addr;
   logic               sample_tick;
   logic               mem_rst;
   logic               running;
   logic               cmd_err;

   wavegen_ctrl #(
      .NUM_WAVES   (NW),
      .DEPTH       (DEPTH),
      .BASE_DIV    (BDIV),
      .FLUSH_CYCLES(FC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .wave_sel   (wave_sel),
      .sample_addr(sample_addr),
      .sample_tick(sample_tick),
      .mem_rst    (mem_rst),
      .running    (running),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: mode 0=idle, 1=flushing, 2=playing; playback timing from cycles elapsed in play.
   int m_mode, m_flush, m_elapsed, m_idx, m_wave, m_rate;
   bit m_run, m_err, m_prev;

   task automatic model_reset();
      m_mode = 0; m_flush = 0; m_elapsed = 0; m_idx = 0; m_wave = 0; m_rate = 0;
      m_run = 0; m_err = 0; m_prev = 0;
   endtask

   function automatic int period();
      return BDIV << m_rate;
   endfunction

   function automatic bit would_tick();
      return (m_mode == 2) && ((m_elapsed % period()) == period() - 1);
   endfunction

   // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model.
   task automatic step(input bit v, input logic [7:0] c);
      bit acc, legal, etick;
      @(negedge clk);
      cmd_valid = v;
      cmd = c;
      #1;
      acc   = v && !m_prev;
      legal = acc && (c[7:4] < NW);
      etick = would_tick() && !legal;
      check_val("sample_tick", sample_tick, etick);
      check_val("mem_rst", mem_rst, m_mode == 1);
      check_val("running", running, m_mode == 2);
      check_val("wave_sel", wave_sel, m_wave);
      check_val("sample_addr", sample_addr, m_wave * DEPTH + m_idx);
      check_val("cmd_err", cmd_err, m_err);
      @(posedge clk);
      m_prev = v;
      if (legal) begin
         m_wave = c[7:4]; m_rate = c[2:0]; m_run = c[3];
         m_idx = 0; m_mode = 1; m_flush = 0;
      end else begin
         if (acc) m_err = 1;
         if (m_mode == 1) begin
            m_flush++;
            if (m_flush == FC) begin
               m_mode = m_run ? 2 : 0;
               m_elapsed = 0;
            end
         end else if (m_mode == 2) begin
            if (etick) m_idx = (m_idx + 1) % DEPTH;
            m_elapsed++;
         end
      end
   endtask

   // Asynchronous reset asserted between clock edges; outputs must clear at once.
   task automatic do_reset();
      @(negedge clk);
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_val("rst_tick", sample_tick, 0);
      check_val("rst_mem_rst", mem_rst, 0);
      check_val("rst_running", running, 0);
      check_val("rst_wave_sel", wave_sel, 0);
      check_val("rst_addr", sample_addr, 0);
      check_val("rst_cmd_err", cmd_err, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   logic [7:0] rc;
   int         hold, gap, guard;

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      repeat (20) step(0, 8'h00);
      // Wave 1, run, rate 1.
      step(1, 8'h19);
      repeat (60) step(0, 8'h19);
      // Wave 0, rate 0: full index wrap.
      step(1, 8'h08);
      repeat (45) step(0, 8'h00);
      // Illegal selector while running.
      step(1, 8'h58);
      repeat (10) step(0, 8'h00);
      // Legal command landing on a tick cycle.
      guard = 0;
      while (!would_tick() && guard < 100) begin
         step(0, 8'h00);
         guard++;
      end
      step(1, 8'h28);
      repeat (30) step(0, 8'h00);
      // Held strobe counts once.
      step(0, 8'h00);
      repeat (50) step(1, 8'h19);
      repeat (20) step(0, 8'h00);
      // Stop command while running.
      step(1, 8'h30);
      repeat (30) step(0, 8'h00);
      // New command during flush restarts it.
      step(1, 8'h19);
      step(0, 8'h00);
      step(1, 8'h2A);
      repeat (40) step(0, 8'h00);
      // Reset mid-operation, then long quiet period.
      step(1, 8'h09);
      repeat (10) step(0, 8'h00);
      do_reset();
      repeat (5000) step(0, 8'h00);

      // Random traffic.
      repeat (400) begin
         rc = 8'($urandom);
         if ($urandom_range(0, 3) != 0) rc[2:0] = 3'($urandom_range(0, 2));
         hold = $urandom_range(1, 3);
         gap  = $urandom_range(1, 60);
         repeat (hold) step(1, rc);
         repeat (gap) step(0, rc);
         if ($urandom_range(0, 49) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
